instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the multicycle RISC-V core.
- Replaces the fixed, hard-coded instruction ROM with a writable word array.
- Fetch side uses a request/grant/valid handshake with programmable wait states.
- Load port lets the bench or a boot loader program the array.
- Out-of-range and misaligned fetches are flagged as errors instead of silently returning zero.

Parameters:
ADDR_W, 14, byte-address width of fetch_addr and load_addr
DATA_W, 32, word width; power of two and at least 8; OFF_W = log2(DATA_W/8)
DEPTH, 4096, number of implemented words; must be at most 2**(ADDR_W-OFF_W)
WAIT_STATES, 0, extra cycles between grant and response (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fetch_req  in  1  fetch request, held until granted
fetch_addr  in  ADDR_W  byte address of the instruction
fetch_gnt  out  1  combinational; request accepted this cycle
rdata_valid  out  1  one-cycle pulse; rdata and rdata_err are valid
rdata  out  DATA_W  fetched word; held until the next response
rdata_err  out  1  fetch was out of range or misaligned (or parity error; see Optional Feature)
load_we  in  1  write the load word this cycle
load_addr  in  ADDR_W  byte address for load
load_data  in  DATA_W  word to write
load_err  out  1  registered; last load was dropped (out of range or misaligned)
busy  out  1  high in WAIT state

Behaviour:
- Word index is addr[ADDR_W-1:OFF_W]; offset is addr[OFF_W-1:0].
- Reset (asynchronous): state IDLE, wait counter 0, rdata_valid=0, rdata=0, rdata_err=0, load_err=0, busy=0. Array contents are not cleared by reset.
- FSM states are IDLE, WAIT and RESP.
- fetch_gnt = fetch_req && !load_we && state!=WAIT. Load has priority: when load_we and fetch_req are high together, the load happens and gnt=0.
- On grant:
  - Latch the address.
  - If WAIT_STATES==0, go to RESP.
  - Otherwise load the counter with WAIT_STATES and go to WAIT.
- WAIT: decrement the counter each cycle; at 1, go to RESP. busy=1 throughout WAIT.
- Array read is sampled on the edge entering RESP. rdata_valid=1 for exactly that RESP cycle.
- Latency: rdata_valid is asserted 1+WAIT_STATES cycles after the grant cycle.
- RESP: a new grant is allowed in the same cycle, giving back-to-back throughput of 1 word per cycle at WAIT_STATES=0. With no grant, go to IDLE.
- Error responses:
  - If index>=DEPTH or offset!=0: rdata=0, rdata_err=1, array not read.
  - Otherwise rdata_err=0.
- Load:
  - With load_we high, a valid address writes the word on the clock edge and clears load_err.
  - An invalid address drops the write and sets load_err=1. load_err holds until the next load.
  - Loads are allowed in any state.
- Read-after-write:
  - A write committed on an edge earlier than the read-sample edge is visible.
  - A write on the same edge as the read sample is not visible; old data is returned.
- Reset mid-WAIT or mid-RESP: the transaction is aborted and no rdata_valid is produced. The next grant starts fresh.
- fetch_addr is ignored except in the grant cycle.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed at load.
  - Adds input port load_par_flip (1 bit). When load_par_flip is high during a load, the stored parity bit is inverted (error injection).
  - On a fetch with a parity mismatch, rdata carries the raw stored word and rdata_err=1.
- Undefined: no parity storage, no load_par_flip port, and rdata_err reflects range/alignment errors only.

Test Plan:
1. WAIT_STATES=0: load 0x00002517 at 0x0 and 0x71c50513 at 0x4; fetch 0x0 then 0x4 back-to-back -> gnt on both cycles; rdata_valid on cycles +1 and +2 with 0x00002517 and 0x71c50513; rdata_err=0.
2. DEPTH=25: fetch 0x64 -> rdata=0, rdata_err=1. Load to 0x64 -> load_err=1; a following fetch of 0x60 still returns its previously loaded value.
3. Fetch 0x6 (misaligned) -> rdata=0, rdata_err=1. Load to 0x2 -> load_err=1.
4. WAIT_STATES=3: request at cycle 0 -> gnt at cycle 0, busy for cycles 1-3, rdata_valid at cycle 4. fetch_req held during WAIT gets no gnt until RESP.
5. Simultaneous events:
   - load_we and fetch_req at 0x8 together -> gnt=0 and the write lands; fetch granted next cycle returns the new data.
   - Load to the fetched address on the read-sample edge -> old data returned.
6. Reset pulsed mid-WAIT (WAIT_STATES=3, cycle 2) -> no rdata_valid, all outputs 0, memory retained; subsequent fetch returns the loaded data. With IMEM_PARITY_EN, a load with load_par_flip=1 followed by a fetch -> rdata_err=1 with the raw data.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Writable instruction memory: req/gnt/valid fetch port with wait states, load port.
// Define IMEM_PARITY_EN for per-word even parity with load-time error injection.
module instr_mem_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_err,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic              load_par_flip,
`endif
  output logic              load_err,
  output logic              busy
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int MEM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic logic addr_ok(
    input logic [ADDR_W-1:0] a
  );
    logic [31:0] idx;
    idx = 32'(a >> OFF_W);
    return (idx < 32'(DEPTH)) &&
           ((a & OFF_MASK) == '0);
  endfunction

  function automatic logic [MEM_W-1:0] addr_idx(
    input logic [ADDR_W-1:0] a
  );
    return MEM_W'(a >> OFF_W);
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;
  logic              lerr_q, lerr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef IMEM_PARITY_EN
  logic              par_q [DEPTH];
`endif

  logic              ld_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ok;
  logic [MEM_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              rd_bad;
  logic              sample;

  assign ld_ok = addr_ok(load_addr);

  // Array has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (load_we && ld_ok) begin
      mem_q[addr_idx(load_addr)] <= load_data;
`ifdef IMEM_PARITY_EN
      par_q[addr_idx(load_addr)] <=
        (^load_data) ^ load_par_flip;
`endif
    end
  end

  always_comb begin
    rd_addr = (state_q == S_WAIT) ? addr_q
                                  : fetch_addr;
    rd_ok   = addr_ok(rd_addr);
    rd_idx  = rd_ok ? addr_idx(rd_addr) : '0;
    rd_word = mem_q[rd_idx];
`ifdef IMEM_PARITY_EN
    rd_bad  = rd_ok &&
              ((^rd_word) != par_q[rd_idx]);
`else
    rd_bad  = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    lerr_d    = lerr_q;
    sample    = 1'b0;
    fetch_gnt = fetch_req && !load_we &&
                (state_q != S_WAIT);

    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (fetch_gnt) begin
          addr_d = fetch_addr;
          if (WS == 4'd0) begin
            state_d = S_RESP;
            sample  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          sample  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sampling on the edge into RESP means a same-edge load is not seen.
    if (sample) begin
      rvalid_d = 1'b1;
      unique case (1'b1)
        !rd_ok: begin
          rdata_d = '0;
          rerr_d  = 1'b1;
        end
        rd_bad: begin
          rdata_d = rd_word;
          rerr_d  = 1'b1;
        end
        default: begin
          rdata_d = rd_word;
          rerr_d  = 1'b0;
        end
      endcase
    end

    if (load_we) begin
      lerr_d = !ld_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      lerr_q   <= lerr_d;
    end
  end

  assign rdata_valid = rvalid_q;
  assign rdata       = rdata_q;
  assign rdata_err   = rerr_q;
  assign load_err    = lerr_q;
  assign busy        = (state_q == S_WAIT);

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: two instances (0 and 3 wait states, 25 words)
// against a transaction-level model; directed plan items then random traffic.
module tb_instr_mem_ctrl;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int DEP = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    req, we, gnt, vld, rerr, lerr, busy;
  logic [AW-1:0] faddr [2];
  logic [AW-1:0] laddr [2];
  logic [DW-1:0] ldata [2];
  logic [DW-1:0] rdata [2];
`ifdef IMEM_PARITY_EN
  logic [1:0]    flip;
`endif

  instr_mem_ctrl #(
    .ADDR_W(AW), .DATA_W(DW),
    .DEPTH(DEP), .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(req[0]), .fetch_addr(faddr[0]),
    .fetch_gnt(gnt[0]), .rdata_valid(vld[0]),
    .rdata(rdata[0]), .rdata_err(rerr[0]),
    .load_we(we[0]), .load_addr(laddr[0]),
    .load_data(ldata[0]),
`ifdef IMEM_PARITY_EN
    .load_par_flip(flip[0]),
`endif
    .load_err(lerr[0]), .busy(busy[0])
  );

  instr_mem_ctrl #(
    .ADDR_W(AW), .DATA_W(DW),
    .DEPTH(DEP), .WAIT_STATES(3)
  ) u_ws3 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(req[1]), .fetch_addr(faddr[1]),
    .fetch_gnt(gnt[1]), .rdata_valid(vld[1]),
    .rdata(rdata[1]), .rdata_err(rerr[1]),
    .load_we(we[1]), .load_addr(laddr[1]),
    .load_data(ldata[1]),
`ifdef IMEM_PARITY_EN
    .load_par_flip(flip[1]),
`endif
    .load_err(lerr[1]), .busy(busy[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               tag, obs, exp);
    end
  endtask

  // Reference model: per-instance word store and one outstanding fetch.
  logic [DW-1:0] m_mem  [2][32];
  bit            m_flip [2][32];
  bit            pend   [2];
  int            pend_resp [2];
  logic [AW-1:0] pend_addr [2];
  bit            e_vld  [2];
  logic [DW-1:0] e_rdata[2];
  bit            e_rerr [2];
  bit            e_lerr [2];
  bit            e_gnt  [2];

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a >> 2);
  endfunction

  function automatic bit ok(input logic [AW-1:0] a);
    return (widx(a) < DEP) && (a[1:0] == 2'b00);
  endfunction

  function automatic bit flip_in(input int k);
`ifdef IMEM_PARITY_EN
    return flip[k];
`else
    return (k < 0);
`endif
  endfunction

  function automatic string tg(input string s,
                               input int k);
    return $sformatf("%s[%0d]@%0d", s, k, cyc);
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit waiting;
      waiting = pend[k] && (cyc < pend_resp[k]);
      e_gnt[k] = req[k] && !we[k] && !waiting;
      chk(tg("gnt", k),  32'(gnt[k]),  32'(e_gnt[k]));
      chk(tg("busy", k), 32'(busy[k]), 32'(waiting));
      chk(tg("vld", k),  32'(vld[k]),  32'(e_vld[k]));
      chk(tg("rdata", k), rdata[k], e_rdata[k]);
      chk(tg("rerr", k), 32'(rerr[k]), 32'(e_rerr[k]));
      chk(tg("lerr", k), 32'(lerr[k]), 32'(e_lerr[k]));
      if (e_gnt[k]) begin
        pend[k]      = 1'b1;
        pend_resp[k] = cyc + 1 + ws(k);
        pend_addr[k] = faddr[k];
      end else if (pend[k] && cyc >= pend_resp[k]) begin
        pend[k] = 1'b0;
      end
      e_vld[k] = 1'b0;
      if (pend[k] && cyc == pend_resp[k] - 1) begin
        e_vld[k] = 1'b1;
        if (!ok(pend_addr[k])) begin
          e_rdata[k] = '0;
          e_rerr[k]  = 1'b1;
        end else begin
          e_rdata[k] = m_mem[k][widx(pend_addr[k])];
          e_rerr[k]  = m_flip[k][widx(pend_addr[k])];
        end
      end
      if (we[k]) begin
        if (ok(laddr[k])) begin
          m_mem[k][widx(laddr[k])]  = ldata[k];
          m_flip[k][widx(laddr[k])] = flip_in(k);
          e_lerr[k] = 1'b0;
        end else begin
          e_lerr[k] = 1'b1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0;
    we  = '0;
`ifdef IMEM_PARITY_EN
    flip = '0;
`endif
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k]    = 1'b0;
      e_vld[k]   = 1'b0;
      e_rdata[k] = '0;
      e_rerr[k]  = 1'b0;
      e_lerr[k]  = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] v, vold, vnew;
  logic [31:0]   r;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      faddr[k] = '0;
      laddr[k] = '0;
      ldata[k] = '0;
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = '0;
        m_flip[k][i] = 1'b0;
      end
    end
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // Preload every implemented word in both instances.
    for (int i = 0; i < DEP; i++) begin
      v = (i == 0) ? 32'h00002517 :
          (i == 1) ? 32'h71c50513 : $urandom;
      we = 2'b11;
      for (int k = 0; k < 2; k++) begin
        laddr[k] = AW'(i * 4);
        ldata[k] = v;
      end
      tick();
    end
    idle_inputs();
    tick();

    // Back-to-back fetches with no wait states.
    req[0] = 1'b1; faddr[0] = 14'h0;
    #1;
    chk("b2b_gnt0", 32'(gnt[0]), 32'd1);
    tick();
    faddr[0] = 14'h4;
    #1;
    chk("b2b_gnt1", 32'(gnt[0]), 32'd1);
    chk("b2b_d0", rdata[0], 32'h00002517);
    chk("b2b_v0", 32'(vld[0]), 32'd1);
    tick();
    req[0] = 1'b0;
    chk("b2b_d1", rdata[0], 32'h71c50513);
    chk("b2b_e1", 32'(rerr[0]), 32'd0);
    tick();

    // Out of range fetch and load.
    v = m_mem[0][24];
    req[0] = 1'b1; faddr[0] = 14'h64;
    tick();
    req[0] = 1'b0;
    chk("oor_d", rdata[0], 32'd0);
    chk("oor_e", 32'(rerr[0]), 32'd1);
    we[0] = 1'b1; laddr[0] = 14'h64;
    ldata[0] = 32'hdeadbeef;
    tick();
    we[0] = 1'b0;
    chk("oor_lerr", 32'(lerr[0]), 32'd1);
    req[0] = 1'b1; faddr[0] = 14'h60;
    tick();
    req[0] = 1'b0;
    chk("last_word", rdata[0], v);

    // Misaligned fetch and load.
    req[0] = 1'b1; faddr[0] = 14'h6;
    tick();
    req[0] = 1'b0;
    chk("mis_d", rdata[0], 32'd0);
    chk("mis_e", 32'(rerr[0]), 32'd1);
    we[0] = 1'b1; laddr[0] = 14'h2;
    tick();
    we[0] = 1'b0;
    chk("mis_lerr", 32'(lerr[0]), 32'd1);
    tick();

    // Three wait states, request held through WAIT.
    req[1] = 1'b1; faddr[1] = 14'h8;
    tick();
    faddr[1] = 14'hc;
    chk("ws_busy", 32'(busy[1]), 32'd1);
    chk("ws_nognt", 32'(gnt[1]), 32'd0);
    tick();
    tick();
    tick();
    chk("ws_vld", 32'(vld[1]), 32'd1);
    chk("ws_gnt", 32'(gnt[1]), 32'd1);
    chk("ws_busy0", 32'(busy[1]), 32'd0);
    tick();
    req[1] = 1'b0;
    repeat (5) tick();

    // Load wins over fetch in the same cycle.
    vnew = $urandom;
    we[0] = 1'b1; laddr[0] = 14'h8; ldata[0] = vnew;
    req[0] = 1'b1; faddr[0] = 14'h8;
    #1;
    chk("prio_gnt", 32'(gnt[0]), 32'd0);
    tick();
    we[0] = 1'b0;
    tick();
    req[0] = 1'b0;
    chk("prio_d", rdata[0], vnew);

    // Load on the read-sample edge is not seen.
    vold = m_mem[1][4];
    req[1] = 1'b1; faddr[1] = 14'h10;
    tick();
    req[1] = 1'b0;
    tick();
    tick();
    we[1] = 1'b1; laddr[1] = 14'h10;
    ldata[1] = ~vold;
    tick();
    we[1] = 1'b0;
    chk("raw_old", rdata[1], vold);
    tick();

    // Reset in the middle of WAIT.
    v = m_mem[1][5];
    req[1] = 1'b1; faddr[1] = 14'h14;
    tick();
    req[1] = 1'b0;
    tick();
    reset_pulse();
    chk("rst_vld", 32'(vld[1]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    repeat (5) tick();
    req[1] = 1'b1; faddr[1] = 14'h14;
    tick();
    req[1] = 1'b0;
    repeat (3) tick();
    chk("rst_keep", rdata[1], v);
    tick();

`ifdef IMEM_PARITY_EN
    vnew = $urandom;
    we[0] = 1'b1; flip[0] = 1'b1;
    laddr[0] = 14'h18; ldata[0] = vnew;
    tick();
    we[0] = 1'b0; flip[0] = 1'b0;
    req[0] = 1'b1; faddr[0] = 14'h18;
    tick();
    req[0] = 1'b0;
    chk("par_e", 32'(rerr[0]), 32'd1);
    chk("par_d", rdata[0], vnew);
    tick();
`endif

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse();
      end
      for (int k = 0; k < 2; k++) begin
        if (!(req[k] && !e_gnt[k])) begin
          req[k] = ($urandom_range(0, 1) == 1);
          r = $urandom;
          faddr[k] = (r[3:0] == 4'd0) ?
                     AW'(r[12:6]) : AW'(r[12:6] & 7'h7c);
        end
        we[k] = ($urandom_range(0, 3) == 0);
        r = $urandom;
        laddr[k] = (r[3:0] == 4'd0) ?
                   AW'(r[12:6]) : AW'(r[12:6] & 7'h7c);
        ldata[k] = $urandom;
`ifdef IMEM_PARITY_EN
        flip[k] = ($urandom_range(0, 7) == 0);
`endif
      end
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
